// File: rtl/uart_block_packer_if.sv
// Handshake and byte-stream bundle between the UART RX deserializer, the
// block packer and the Kuznechik cipher input.
interface uart_block_packer_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_error;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [3:0]   byte_cnt;
  logic         overrun;
  logic         timeout;

  // Packer side: consumes bytes and the ready, produces the block and status
  modport slave (
    input  rx_data, rx_valid, rx_error, blk_ready,
    output blk_data, blk_valid, byte_cnt, overrun, timeout
  );

  // Environment side: produces bytes and the ready, observes the block
  modport master (
    output rx_data, rx_valid, rx_error, blk_ready,
    input  blk_data, blk_valid, byte_cnt, overrun, timeout
  );
endinterface

// File: rtl/uart_block_packer.sv
// uart_block_packer: packs 16 UART bytes (first byte in the MSBs) into one
// 128-bit block, offers it under valid/ready and flags dropped bytes.
// Optional macro RX_TIMEOUT_EN: discard a partial block after
// TIMEOUT_CYCLES idle cycles and pulse timeout.
module uart_block_packer #(
  parameter int TIMEOUT_CYCLES = 86_800,
  parameter int CNT_W          = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_block_packer_if.slave   bus
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t         state_q;
  logic [127:0]   shift_q;
  logic [3:0]     cnt_q;
  logic           vld_q;
  logic           ovr_q;
  logic           to_q;
  logic           timeout_hit;
  logic           byte_ok;

  // A byte is usable only when it arrives without a framing error
  assign byte_ok = bus.rx_valid && !bus.rx_error;

`ifdef RX_TIMEOUT_EN
  logic [CNT_W-1:0] idle_q;
  logic [CNT_W-1:0] idle_d;

  // Expiry is the idle edge that would bring the counter to TIMEOUT_CYCLES
  assign timeout_hit = (state_q == FILL) && (cnt_q != 4'd0) && !bus.rx_valid &&
                       !bus.rx_error && (idle_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle counter next state: clear on bytes, empty partial, errors and expiry
  always_comb begin
    idle_d = idle_q;
    if (state_q == FILL) begin
      if (bus.rx_valid || bus.rx_error || cnt_q == 4'd0 || timeout_hit)
        idle_d = '0;
      else
        idle_d = idle_q + 1'b1;
    end else if (byte_ok && bus.blk_ready) begin
      idle_d = '0;
    end
  end

  // Idle counter register
  always_ff @(posedge clk) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Fill/hold state machine with registered block, count and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      shift_q <= '0;
      cnt_q   <= 4'd0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      to_q  <= 1'b0;
      case (state_q)
        FILL: begin
          if (bus.rx_error) begin
            cnt_q <= 4'd0;
            ovr_q <= 1'b1;
          end else if (bus.rx_valid) begin
            shift_q <= {shift_q[119:0], bus.rx_data};
            if (cnt_q == 4'd15) begin
              cnt_q   <= 4'd0;
              vld_q   <= 1'b1;
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else if (timeout_hit) begin
            cnt_q <= 4'd0;
            to_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.blk_ready) begin
            vld_q   <= 1'b0;
            state_q <= FILL;
            // A clean byte in the handshake cycle opens the next block
            if (byte_ok) begin
              shift_q <= {shift_q[119:0], bus.rx_data};
              cnt_q   <= 4'd1;
            end else if (bus.rx_valid) begin
              ovr_q <= 1'b1;
            end
          end else if (bus.rx_valid) begin
            ovr_q <= 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.blk_data  = shift_q;
  assign bus.blk_valid = vld_q;
  assign bus.byte_cnt  = cnt_q;
  assign bus.overrun   = ovr_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_uart_block_packer.sv
// Self-checking bench for uart_block_packer with a block scoreboard.
module tb_uart_block_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [127:0] m_shift = '0;
  int           m_n = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_blk;

  uart_block_packer_if bus ();

  uart_block_packer #(.TIMEOUT_CYCLES(100), .CNT_W(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one clean byte and record it in the reference model
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    m_shift = {m_shift[119:0], b};
    m_n++;
    if (m_n == 16) begin
      exp_q.push_back(m_shift);
      m_n = 0;
    end
  endtask

  task automatic pop_exp();
    if (exp_q.size() > 0) exp_blk = exp_q.pop_front();
    else                  exp_blk = 'x;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({bus.blk_valid, bus.overrun, bus.timeout, bus.byte_cnt} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {bus.blk_valid, bus.overrun, bus.timeout, bus.byte_cnt});
    end
    checks++;
    if (bus.blk_data !== 128'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", bus.blk_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_block();
    bus.blk_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      if (i == 6) begin
        checks++;
        if (bus.byte_cnt !== 4'd7) begin
          errors++;
          $display("FAIL basic_cnt got %0d want 7", bus.byte_cnt);
        end
      end
    end
    pop_exp();
    checks++;
    if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp_blk) begin
      errors++;
      $display("FAIL basic_blk got v=%b %h want v=1 %h", bus.blk_valid, bus.blk_data, exp_blk);
    end
    checks++;
    if (bus.blk_data !== 128'h000102030405060708090A0B0C0D0E0F) begin
      errors++;
      $display("FAIL basic_const got %h want 000102030405060708090a0b0c0d0e0f", bus.blk_data);
    end
    step();
    checks++;
    if (bus.blk_valid !== 1'b0 || bus.byte_cnt !== 4'd0) begin
      errors++;
      $display("FAIL basic_after got v=%b cnt=%0d want v=0 cnt=0", bus.blk_valid, bus.byte_cnt);
    end
  endtask

  task automatic test_overrun();
    bus.blk_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
    pop_exp();
    checks++;
    if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp_blk) begin
      errors++;
      $display("FAIL ovr_blk got v=%b %h want v=1 %h", bus.blk_valid, bus.blk_data, exp_blk);
    end
    // Extra byte in HOLD is dropped, so it never enters the model
    bus.rx_data  = 8'hAA;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1 || bus.blk_valid !== 1'b1 || bus.blk_data !== exp_blk) begin
      errors++;
      $display("FAIL ovr_pulse got o=%b v=%b %h want o=1 v=1 %h", bus.overrun, bus.blk_valid, bus.blk_data, exp_blk);
    end
    step();
    checks++;
    if (bus.overrun !== 1'b0 || bus.blk_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_once got o=%b v=%b want o=0 v=1", bus.overrun, bus.blk_valid);
    end
    bus.blk_ready = 1'b1;
    step();
    bus.blk_ready = 1'b0;
    checks++;
    if (bus.blk_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_release got v=%b want 0", bus.blk_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.blk_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
    pop_exp();
    checks++;
    if (bus.blk_data !== exp_blk) begin
      errors++;
      $display("FAIL b2b_first got %h want %h", bus.blk_data, exp_blk);
    end
    bus.blk_ready = 1'b1;
    send_byte(8'h55);
    bus.blk_ready = 1'b0;
    checks++;
    if (bus.blk_valid !== 1'b0 || bus.byte_cnt !== 4'd1 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hs got v=%b cnt=%0d o=%b want v=0 cnt=1 o=0", bus.blk_valid, bus.byte_cnt, bus.overrun);
    end
    for (int i = 0; i < 15; i++) send_byte(8'h56 + 8'(i));
    pop_exp();
    checks++;
    if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp_blk || bus.blk_data[127:120] !== 8'h55) begin
      errors++;
      $display("FAIL b2b_second got v=%b %h want v=1 %h", bus.blk_valid, bus.blk_data, exp_blk);
    end
    bus.blk_ready = 1'b1;
    step();
  endtask

  task automatic test_error();
    bus.blk_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i));
    checks++;
    if (bus.byte_cnt !== 4'd5) begin
      errors++;
      $display("FAIL err_pre got %0d want 5", bus.byte_cnt);
    end
    bus.rx_error = 1'b1;
    step();
    bus.rx_error = 1'b0;
    m_n = 0;
    checks++;
    if (bus.byte_cnt !== 4'd0 || bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL err_clear got cnt=%0d o=%b want cnt=0 o=1", bus.byte_cnt, bus.overrun);
    end
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    pop_exp();
    checks++;
    if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp_blk ||
        bus.blk_data !== 128'h101112131415161718191A1B1C1D1E1F) begin
      errors++;
      $display("FAIL err_block got v=%b %h want v=1 %h", bus.blk_valid, bus.blk_data, exp_blk);
    end
    step();
  endtask

  task automatic test_timeout();
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    bus.blk_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
    for (int i = 1; i <= 150; i++) begin
      step();
      if (bus.timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
`ifdef RX_TIMEOUT_EN
    checks++;
    if (pulses !== 1 || first !== 100) begin
      errors++;
      $display("FAIL to_pulse got n=%0d at=%0d want n=1 at=100", pulses, first);
    end
    checks++;
    if (bus.byte_cnt !== 4'd0) begin
      errors++;
      $display("FAIL to_cnt got %0d want 0", bus.byte_cnt);
    end
`else
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL to_none got %0d pulses want 0", pulses);
    end
    checks++;
    if (bus.byte_cnt !== 4'd3) begin
      errors++;
      $display("FAIL to_hold got %0d want 3", bus.byte_cnt);
    end
`endif
    bus.rx_error = 1'b1;
    step();
    bus.rx_error = 1'b0;
    m_n = 0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.blk_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'h70 + 8'(i));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_n = 0;
    checks++;
    if ({bus.blk_valid, bus.overrun, bus.timeout, bus.byte_cnt} !== 7'd0 || bus.blk_data !== 128'd0) begin
      errors++;
      $display("FAIL rstmid_state got v=%b cnt=%0d %h want all 0", bus.blk_valid, bus.byte_cnt, bus.blk_data);
    end
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i));
    pop_exp();
    checks++;
    if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp_blk) begin
      errors++;
      $display("FAIL rstmid_block got v=%b %h want v=1 %h", bus.blk_valid, bus.blk_data, exp_blk);
    end
    step();
    // Reset while holding a block drops it without any pulse
    bus.blk_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'h90 + 8'(i));
    pop_exp();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (bus.blk_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.blk_data !== 128'd0) begin
      errors++;
      $display("FAIL rsthold got v=%b o=%b %h want 0", bus.blk_valid, bus.overrun, bus.blk_data);
    end
  endtask

  initial begin
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.rx_error  = 1'b0;
    bus.blk_ready = 1'b0;
    test_reset();
    test_basic_block();
    test_overrun();
    test_back_to_back();
    test_error();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_block_packer.md
# uart_block_packer

Assembles the byte stream from the UART receiver into 128-bit blocks for the Kuznechik cipher core. Sits between the UART RX deserializer and the cipher input inside `crypto`. Collects 16 bytes, presents one block under a valid/ready handshake, and reports dropped bytes. Optionally discards a partial block after an idle timeout so a host can resynchronise.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, 86_800: idle clock cycles (≈20 byte times at 115200 baud, 50 MHz) before a partial block is discarded; only used with `RX_TIMEOUT_EN`.
- `CNT_W`, 17: width of the idle counter; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_data`  in  8  received byte, valid when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `rx_error`  in  1  one-cycle strobe, framing error on the current byte; may coincide with `rx_valid`.
- `blk_data`  out  128  assembled block; first received byte in [127:120], 16th in [7:0].
- `blk_valid`  out  1  block available.
- `blk_ready`  in  1  cipher core accepts the block.
- `byte_cnt`  out  4  bytes held in the partial block (0–15).
- `overrun`  out  1  one-cycle pulse: a byte was dropped.
- `timeout`  out  1  one-cycle pulse: partial block discarded on idle.

## Operation

- Two states: FILL, HOLD. Reset → FILL, `byte_cnt`=0, `blk_data`=0, `blk_valid`=0, `overrun`=0, `timeout`=0, idle counter 0.
- FILL, `rx_valid`=1, `rx_error`=0: shift register shifts left 8 bits, `rx_data` enters [7:0]; `byte_cnt`++. When the byte is the 16th (`byte_cnt` was 15): `byte_cnt`→0, state→HOLD, `blk_valid`→1.
- FILL, `rx_error`=1 (with or without `rx_valid`): byte discarded, partial block cleared (`byte_cnt`→0), `overrun` pulses.
- HOLD: `blk_data` frozen, `blk_valid`=1 until `blk_valid & blk_ready`. On handshake → FILL, `blk_valid`→0.
- HOLD, `rx_valid` without handshake in the same cycle: byte dropped, `overrun` pulses.
- HOLD, `rx_valid` (no error) in the handshake cycle: byte accepted as byte 0 of the next block, `byte_cnt`→1, no `overrun`.
- `blk_ready` ignored in FILL.
- `byte_cnt` never wraps past 15; the 16th byte transfers to HOLD.

## Timing

- `blk_valid` rises on the clock edge that samples the 16th `rx_valid`; latency 1 cycle from strobe to visible block.
- Handshake completes on the edge where `blk_valid`=`blk_ready`=1; `blk_valid` low the following cycle unless another block is complete (impossible within 16 byte times).
- `overrun`/`timeout` are registered, high for exactly one cycle after the offending edge.
- Idle counter: cleared on every accepted byte and while `byte_cnt`=0 in FILL; counts otherwise in FILL; held in HOLD.
- `rst_n` low mid-block or in HOLD: everything returns to reset values on that edge; pending block lost, no pulse.

## Configuration

- `RX_TIMEOUT_EN` defined: in FILL with `byte_cnt`>0, when the idle counter reaches `TIMEOUT_CYCLES` without a new byte, `byte_cnt`→0, counter→0, `timeout` pulses once. A byte arriving on the expiry cycle wins: accepted, no timeout.
- Not defined: idle counter not built, `timeout` tied 0, partial block held indefinitely.

## Test plan

- Send bytes 0x00..0x0F, `blk_ready`=1 → one `blk_valid` cycle with `blk_data`=128'h000102030405060708090A0B0C0D0E0F, `byte_cnt` back to 0.
- Send 16 bytes with `blk_ready`=0, then one extra byte 0xAA → `blk_valid` held, `blk_data` unchanged, `overrun` pulses once; raise `blk_ready` → `blk_valid` drops next cycle.
- Assert `blk_ready` in the same cycle as `rx_valid` with 0x55 while in HOLD → handshake completes, `byte_cnt`=1, next block starts with 0x55 in [127:120], no `overrun`.
- Send 5 bytes then `rx_error` → `byte_cnt`=0, `overrun` pulse; following 16 bytes 0x10..0x1F form block 128'h101112...1F.
- With `RX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100: send 3 bytes, idle 100 cycles → `timeout` pulse, `byte_cnt`=0; without the macro → `byte_cnt` stays 3, `timeout` never asserts.
- Pull `rst_n` low after 8 bytes for one cycle → all outputs at reset values; next 16 bytes produce a complete correct block.
